shift_arbiter: RTL and testbench

// Shares one combinational barrel_shifter between two requesters: port 0 (execute-stage ALU shifts) and port 1 (load/store byte-lane alignment).

---
 rtl/shift_arbiter_pkg.sv | 25 ++
 rtl/shift_arbiter_barrel_shifter.sv | 32 +++
 rtl/shift_arbiter.sv | 99 +++++++++
 tb/tb_shift_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift arbiter: op encodings, widths, result-register state
// and the round-robin winner function.
package shift_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } rsp_state_e;

  // A lone requester always wins; on contention the port that did not win last time goes.
  function automatic logic arb_winner(input logic [1:0] valid, input logic rr_ptr);
    if (valid == 2'b11) begin
      return ~rr_ptr;
    end
    return valid[1];
  endfunction

endpackage

// File: rtl/shift_arbiter_barrel_shifter.sv
// Log-depth combinational barrel shifter producing left and right results in parallel;
// the right result fills with the sign bit when shift_arithmetic is set.
module barrel_shifter #(
  parameter int unsigned SIZE = 32
) (
  input  logic [SIZE-1:0]         in_a,
  input  logic [$clog2(SIZE)-1:0] in_b,
  input  logic                    shift_arithmetic,
  output logic [SIZE-1:0]         result_l,
  output logic [SIZE-1:0]         result_r
);

  localparam int unsigned StageCnt = $clog2(SIZE);

  logic fill;

  assign fill = shift_arithmetic & in_a[SIZE-1];

  always_comb begin
    result_l = in_a;
    result_r = in_a;
    for (int s = 0; s < StageCnt; s++) begin
      if (in_b[s]) begin
        result_l = result_l << (1 << s);
        // Vacated high bits take the fill value for arithmetic shifts.
        result_r = (result_r >> (1 << s)) |
                   (fill ? ~({SIZE{1'b1}} >> (1 << s)) : {SIZE{1'b0}});
      end
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Two-port round-robin arbiter in front of one shared barrel shifter; the shifted result
// lands in a one-entry register returned on a valid/ready interface with port and tag.
module shift_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][1:0]        req_op,
  input  logic [1:0][DATA_W-1:0] req_data,
  input  logic [1:0][4:0]        req_shamt,
  input  logic [1:0][TAG_W-1:0]  req_tag,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_data,
  output logic                   rsp_port,
  output logic [TAG_W-1:0]       rsp_tag
);

  import shift_arbiter_pkg::*;

  rsp_state_e        state_q;
  logic              rr_ptr_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_port_q;
  logic [TAG_W-1:0]  rsp_tag_q;

  logic              can_accept;
  logic              winner;
  logic              fire;
  logic [1:0]        op_sel;
  logic [DATA_W-1:0] result_l;
  logic [DATA_W-1:0] result_r;
  logic [DATA_W-1:0] shift_result;

  always_comb begin
    can_accept = (state_q == StEmpty) | rsp_ready;
    winner     = arb_winner(req_valid, rr_ptr_q);
    // Gated by rst_n so no request is accepted while reset is asserted.
    fire       = rst_n & (|req_valid) & can_accept;
    req_ready  = fire ? (2'b01 << winner) : 2'b00;
    op_sel     = req_op[winner];
  end

  barrel_shifter #(
    .SIZE(DATA_W)
  ) u_barrel_shifter (
    .in_a            (req_data[winner]),
    .in_b            (req_shamt[winner]),
    .shift_arithmetic(op_sel == OP_SRA),
    .result_l        (result_l),
    .result_r        (result_r)
  );

  // The reserved op encoding behaves as SLL.
  assign shift_result = ((op_sel == OP_SRL) || (op_sel == OP_SRA)) ? result_r : result_l;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StEmpty;
      rr_ptr_q   <= 1'b0;
      rsp_data_q <= '0;
      rsp_port_q <= 1'b0;
      rsp_tag_q  <= '0;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (fire) begin
            state_q    <= StFull;
            rr_ptr_q   <= winner;
            rsp_data_q <= shift_result;
            rsp_port_q <= winner;
            rsp_tag_q  <= req_tag[winner];
          end
        end
        StFull: begin
          if (fire) begin
            // Drain and refill in the same cycle.
            rr_ptr_q   <= winner;
            rsp_data_q <= shift_result;
            rsp_port_q <= winner;
            rsp_tag_q  <= req_tag[winner];
          end else if (rsp_ready) begin
            state_q <= StEmpty;
          end
        end
        default: state_q <= StEmpty;
      endcase
    end
  end

  assign rsp_valid = (state_q == StFull);
  assign rsp_data  = rsp_data_q;
  assign rsp_port  = rsp_port_q;
  assign rsp_tag   = rsp_tag_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed and randomized bench for shift_arbiter against a cycle-level behavioural model.
module tb_shift_arbiter;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0][1:0]   req_op;
  logic [1:0][31:0]  req_data;
  logic [1:0][4:0]   req_shamt;
  logic [1:0][3:0]   req_tag;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_data;
  logic              rsp_port;
  logic [3:0]        rsp_tag;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model of the result register and the last-granted port.
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_port;
  logic [3:0]  m_tag;
  logic        m_last;
  logic        grants[$];

  always #5 clk = ~clk;

  shift_arbiter #(
    .DATA_W(32),
    .TAG_W (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_data (req_data),
    .req_shamt(req_shamt),
    .req_tag  (req_tag),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_port (rsp_port),
    .rsp_tag  (rsp_tag)
  );

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] sh);
    case (op)
      2'b01:   return d >> sh;
      2'b10:   return $signed(d) >>> sh;
      default: return d << sh;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic [1:0] op, input logic [31:0] d,
                         input logic [4:0] sh, input logic [3:0] tag);
    req_op[p]    = op;
    req_data[p]  = d;
    req_shamt[p] = sh;
    req_tag[p]   = tag;
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_port  = 1'b0;
    m_tag   = '0;
    m_last  = 1'b0;
  endtask

  // Called at a falling edge with inputs already driven; advances one clock.
  task automatic cycle();
    logic       any, can, w;
    logic [1:0] exp_rdy;
    #1;
    any     = |req_valid;
    w       = (req_valid == 2'b11) ? ~m_last : req_valid[1];
    can     = !m_valid || rsp_ready;
    exp_rdy = (any && can) ? (2'b01 << w) : 2'b00;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    @(posedge clk);
    if (any && can) begin
      m_valid = 1'b1;
      m_data  = ref_shift(req_op[w], req_data[w], req_shamt[w]);
      m_port  = w;
      m_tag   = req_tag[w];
      m_last  = w;
      grants.push_back(w);
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    if (m_valid) begin
      check("rsp_data", rsp_data, m_data);
      check("rsp_port", 32'(rsp_port), 32'(m_port));
      check("rsp_tag", 32'(rsp_tag), 32'(m_tag));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin : stim
    logic [31:0] held;
    logic        exp_order[4];
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};

    // Reset values, and no acceptance while reset is held.
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    set_req(0, 2'b00, 32'h1, 5'd1, 4'h1);
    set_req(1, 2'b00, 32'h2, 5'd1, 4'h2);
    model_reset();
    #2;
    check("reset_req_ready", 32'(req_ready), 32'h0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_rsp_port", 32'(rsp_port), 32'h0);
    check("reset_rsp_tag", 32'(rsp_tag), 32'h0);
    @(negedge clk);
    @(negedge clk);
    req_valid = 2'b00;
    rst_n     = 1'b1;

    // Port 0 SLL.
    set_req(0, 2'b00, 32'h0000_0001, 5'd4, 4'h5);
    req_valid = 2'b01;
    cycle();
    check("sll_basic", rsp_data, 32'h0000_0010);
    check("sll_tag", 32'(rsp_tag), 32'h5);

    // Port 1 shift-right boundaries.
    set_req(1, 2'b10, 32'h8000_0000, 5'd31, 4'h9);
    req_valid = 2'b10;
    cycle();
    check("sra_31", rsp_data, 32'hFFFF_FFFF);
    set_req(1, 2'b01, 32'h8000_0000, 5'd31, 4'hA);
    cycle();
    check("srl_31", rsp_data, 32'h0000_0001);
    set_req(1, 2'b01, 32'h8000_0000, 5'd0, 4'hB);
    cycle();
    check("srl_0", rsp_data, 32'h8000_0000);
    req_valid = 2'b00;
    cycle();

    // Contention after reset: alternate starting with port 1.
    do_reset();
    set_req(0, 2'b00, 32'h0000_0003, 5'd2, 4'h3);
    set_req(1, 2'b01, 32'hF000_0000, 5'd4, 4'hC);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    grants.delete();
    for (int i = 0; i < 4; i++) cycle();
    check("grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      check($sformatf("grant_order_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    end
    req_valid = 2'b00;
    cycle();

    // Backpressure while full, then drain and refill in one cycle.
    set_req(1, 2'b00, 32'h0000_0007, 5'd1, 4'h7);
    req_valid = 2'b10;
    cycle();
    held = rsp_data;
    set_req(0, 2'b01, 32'h0000_F000, 5'd8, 4'h4);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("stall_hold", rsp_data, held);
    end
    rsp_ready = 1'b1;
    cycle();
    check("refill_port", 32'(rsp_port), 32'h0);
    check("refill_data", rsp_data, 32'h0000_00F0);

    // Asynchronous reset while a result is pending.
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rsp_valid", 32'(rsp_valid), 32'h0);
    check("async_req_ready", 32'(req_ready), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 2'b11;
    cycle();
    check("post_reset_grant", 32'(rsp_port), 32'h1);

    // Reserved op acts as SLL.
    set_req(0, 2'b11, 32'h0000_00FF, 5'd8, 4'hE);
    req_valid = 2'b01;
    cycle();
    check("op11_sll", rsp_data, 32'h0000_FF00);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom_range(0, 3));
      rsp_ready = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 2; p++) begin
        set_req(p, 2'($urandom), $urandom, 5'($urandom), 4'($urandom));
      end
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
